// File: rtl/i2c_target_regs.sv
// I2C target with a 16 x 8-bit register file, pointer auto-increment and a host load port.
// SCL/SDA are oversampled on clk12M; the target only ever pulls SDA low.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h19,
  parameter logic [7:0] WHOAMI      = 8'h33
) (
  input  logic       clk12M,
  input  logic       rst_n,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic       host_wr_en,
  input  logic [3:0] host_wr_addr,
  input  logic [7:0] host_wr_data,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       addr_match,
  output logic       busy
);
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 16;
  localparam int unsigned CW   = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_RX_DATA  = 3'd3;
  localparam logic [2:0] S_RX_ACK   = 3'd4;
  localparam logic [2:0] S_TX_DATA  = 3'd5;
  localparam logic [2:0] S_TX_ACK   = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  logic [2:0]    state, state_nxt;
  logic [1:0]    scl_sync, sda_sync;
  logic          scl_prev, sda_prev;
  logic          sda_oe, sda_oe_nxt;
  logic [DW-1:0] shift, shift_nxt;
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          rw, rw_nxt;
  logic          first, first_nxt;
  logic          busy_nxt, addr_match_nxt, wr_strobe_nxt;
  logic [AW-1:0] wr_addr_nxt;
  logic [DW-1:0] wr_data_nxt;
  logic          i2c_we_c;
  logic [DW-1:0] regs [NREG];

  // Bus edge and condition decode from the synchronized samples
  logic sda_in_c, scl_rise_c, scl_fall_c, start_c, stop_c;
  assign sda_in_c   = sda_sync[1];
  assign scl_rise_c = scl_sync[1] & ~scl_prev;
  assign scl_fall_c = ~scl_sync[1] & scl_prev;
  assign start_c    = scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
  assign stop_c     = scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];

  assign SDA = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk12M or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  always_ff @(posedge clk12M or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and datapath; START/STOP override bit handling
  always_comb begin
    state_nxt      = state;
    sda_oe_nxt     = sda_oe;
    shift_nxt      = shift;
    bit_cnt_nxt    = bit_cnt;
    ptr_nxt        = ptr;
    rw_nxt         = rw;
    first_nxt      = first;
    busy_nxt       = busy;
    addr_match_nxt = 1'b0;
    wr_strobe_nxt  = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    i2c_we_c       = 1'b0;
    if (start_c) begin
      state_nxt   = S_ADDR;
      sda_oe_nxt  = 1'b0;
      bit_cnt_nxt = '0;
    end else if (stop_c) begin
      state_nxt  = S_IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise_c && bit_cnt < CW'(8)) begin
            shift_nxt   = {shift[DW-2:0], sda_in_c};
            bit_cnt_nxt = bit_cnt + CW'(1);
            if (bit_cnt == CW'(7)) begin
              if (shift[6:0] == TARGET_ADDR) begin
                addr_match_nxt = 1'b1;
                busy_nxt       = 1'b1;
                rw_nxt         = sda_in_c;
              end else begin
                state_nxt = S_IGNORE;
              end
            end
          end else if (scl_fall_c && bit_cnt == CW'(8)) begin
            state_nxt   = S_ADDR_ACK;
            sda_oe_nxt  = 1'b1;
            bit_cnt_nxt = '0;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall_c) begin
            if (!rw) begin
              state_nxt   = S_RX_DATA;
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              first_nxt   = 1'b1;
            end else begin
              state_nxt   = S_TX_DATA;
              shift_nxt   = regs[ptr];
              sda_oe_nxt  = ~regs[ptr][DW-1];
              bit_cnt_nxt = CW'(1);
            end
          end
        end
        S_RX_DATA: begin
          if (scl_rise_c && bit_cnt < CW'(8)) begin
            shift_nxt   = {shift[DW-2:0], sda_in_c};
            bit_cnt_nxt = bit_cnt + CW'(1);
          end else if (scl_fall_c && bit_cnt == CW'(8)) begin
            state_nxt  = S_RX_ACK;
            sda_oe_nxt = 1'b1;
            if (first) begin
              ptr_nxt   = shift[AW-1:0];
              first_nxt = 1'b0;
            end else begin
              // 0xF is read-only over the bus but still advances the pointer
              if (ptr != AW'(NREG - 1)) begin
                i2c_we_c      = 1'b1;
                wr_strobe_nxt = 1'b1;
                wr_addr_nxt   = ptr;
                wr_data_nxt   = shift;
              end
              ptr_nxt = ptr + AW'(1);
            end
          end
        end
        S_RX_ACK: begin
          if (scl_fall_c) begin
            state_nxt   = S_RX_DATA;
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
          end
        end
        S_TX_DATA: begin
          if (scl_fall_c) begin
            if (bit_cnt == '0) begin
              sda_oe_nxt  = ~shift[DW-1];
              bit_cnt_nxt = CW'(1);
            end else if (bit_cnt < CW'(8)) begin
              shift_nxt   = {shift[DW-2:0], 1'b0};
              sda_oe_nxt  = ~shift[DW-2];
              bit_cnt_nxt = bit_cnt + CW'(1);
            end else begin
              state_nxt  = S_TX_ACK;
              sda_oe_nxt = 1'b0;
              ptr_nxt    = ptr + AW'(1);
            end
          end
        end
        S_TX_ACK: begin
          if (scl_rise_c) begin
            if (!sda_in_c) begin
              state_nxt   = S_TX_DATA;
              shift_nxt   = regs[ptr];
              bit_cnt_nxt = '0;
            end else begin
              state_nxt = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk12M or negedge rst_n) begin
    if (!rst_n) begin
      sda_oe     <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      first      <= 1'b0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      sda_oe     <= sda_oe_nxt;
      shift      <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      ptr        <= ptr_nxt;
      rw         <= rw_nxt;
      first      <= first_nxt;
      busy       <= busy_nxt;
      addr_match <= addr_match_nxt;
      wr_strobe  <= wr_strobe_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
    end
  end

  // Register file: a bus write lands after a host write to the same index
  always_ff @(posedge clk12M or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= (i == NREG - 1) ? WHOAMI : '0;
    end else begin
      if (host_wr_en) regs[host_wr_addr] <= host_wr_data;
      if (i2c_we_c)   regs[ptr] <= shift;
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged initiator, register-file model and strobe scoreboard.
module tb_i2c_target_regs;
  localparam int unsigned Q = 8;
  localparam logic [6:0] ADDR = 7'h19;

  logic       clk12M = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic       host_wr_en = 1'b0;
  logic [3:0] host_wr_addr = '0;
  logic [7:0] host_wr_data = '0;
  logic       wr_strobe, addr_match, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_oe ? 1'b0 : 1'bz;

  i2c_target_regs dut (
    .clk12M(clk12M), .rst_n(rst_n), .SCL(scl), .SDA(sda_bus),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .addr_match(addr_match), .busy(busy)
  );

  always #40 clk12M = ~clk12M;

  int n_total = 0;
  int n_pass = 0;
  logic [7:0]  mregs [16];
  logic [3:0]  mptr;
  logic [11:0] exp_wr [$];
  logic [7:0]  rd_log [$];
  int          exp_match = 0;
  int          seen_match = 0;
  logic [11:0] cmp_e;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = (i == 15) ? 8'h33 : 8'h00;
    mptr = '0;
    exp_wr.delete();
  endtask

  // Scoreboard: every write strobe must match the oldest expected register write
  always @(negedge clk12M) begin
    if (rst_n) begin
      if (wr_strobe) begin
        if (exp_wr.size() == 0) check("wr_strobe_unexpected", 1, 0);
        else begin
          cmp_e = exp_wr.pop_front();
          check("wr_addr", int'(wr_addr), int'(cmp_e[11:8]));
          check("wr_data", int'(wr_data), int'(cmp_e[7:0]));
        end
      end
      if (addr_match) seen_match++;
    end
  end

  initial begin
    #8000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk12M);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; wait_q(); scl = 1'b1; wait_q(); m_oe = 1'b1; wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; wait_q(); scl = 1'b1; wait_q(); m_oe = 1'b0; wait_q(); wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_oe = ~b; wait_q(); scl = 1'b1; wait_q(); wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_oe = 1'b0; wait_q(); scl = 1'b1; wait_q(); b = sda_bus; wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic v;
    b = '0;
    for (int i = 7; i >= 0; i--) begin read_bit(v); b[i] = v; end
    write_bit(nack);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk12M);
    host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
    @(negedge clk12M);
    host_wr_en = 1'b0;
    mregs[a] = d;
  endtask

  task automatic end_txn();
    i2c_stop();
    check("busy_after_stop", int'(busy), 0);
    check("strobes_drained", exp_wr.size(), 0);
    check("addr_match_count", seen_match, exp_match);
  endtask

  // Pointer byte then n data bytes taken from data[7:0], data[15:8], ...
  task automatic wr_txn(input logic [7:0] ptr_byte, input logic [31:0] data, input int n);
    logic ack;
    logic [7:0] b;
    i2c_start();
    write_byte({ADDR, 1'b0}, ack); check("addr_w_ack", int'(ack), 0); exp_match++;
    check("busy_after_match", int'(busy), 1);
    write_byte(ptr_byte, ack); check("ptr_ack", int'(ack), 0);
    mptr = ptr_byte[3:0];
    for (int i = 0; i < n; i++) begin
      b = data[8*i +: 8];
      if (mptr != 4'hF) begin mregs[mptr] = b; exp_wr.push_back({mptr, b}); end
      mptr++;
      write_byte(b, ack); check("data_ack", int'(ack), 0);
    end
    end_txn();
  endtask

  // Optional pointer write and repeated START, then n reads with NACK on the last
  task automatic rd_txn(input logic set_ptr, input logic [3:0] p, input int n);
    logic ack;
    logic [7:0] b;
    rd_log.delete();
    i2c_start();
    if (set_ptr) begin
      write_byte({ADDR, 1'b0}, ack); check("addr_w_ack", int'(ack), 0); exp_match++;
      write_byte({4'h0, p}, ack); check("ptr_ack", int'(ack), 0);
      mptr = p;
      i2c_start();
    end
    write_byte({ADDR, 1'b1}, ack); check("addr_r_ack", int'(ack), 0); exp_match++;
    for (int i = 0; i < n; i++) begin
      read_byte(b, i == n - 1);
      check("rd_data", int'(b), int'(mregs[mptr]));
      rd_log.push_back(b);
      mptr++;
    end
    check("sda_released_after_nack", int'(sda_bus), 1);
    end_txn();
  endtask

  task automatic mismatch(input logic [7:0] abyte);
    logic ack;
    i2c_start();
    write_byte(abyte, ack);
    check("mismatch_nack", int'(ack), 1);
    check("mismatch_busy", int'(busy), 0);
    check("mismatch_no_match", seen_match, exp_match);
  endtask

  initial begin
    logic ack, v;
    logic [6:0] bad;
    int kind;
    model_reset();
    repeat (3) @(negedge clk12M);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_strobe", int'(wr_strobe), 0);
    check("rst_addr_match", int'(addr_match), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_sda", int'(sda_bus), 1);
    rst_n = 1'b1;
    wait_q();

    wr_txn(8'h03, 32'h0000_5AA5, 2);
    rd_txn(1'b1, 4'h3, 2);
    check("lit_reg3", int'(rd_log[0]), 8'hA5);
    check("lit_reg4", int'(rd_log[1]), 8'h5A);

    host_write(4'h0, 8'h11);
    host_write(4'h1, 8'h22);
    rd_txn(1'b1, 4'h0, 2);
    check("lit_reg0", int'(rd_log[0]), 8'h11);
    check("lit_reg1", int'(rd_log[1]), 8'h22);

    rd_txn(1'b1, 4'hF, 1);
    check("lit_whoami", int'(rd_log[0]), 8'h33);
    wr_txn(8'h0F, 32'h0, 1);
    rd_txn(1'b1, 4'hF, 1);
    check("lit_whoami_after_wr", int'(rd_log[0]), 8'h33);

    host_write(4'hE, 8'h77);
    rd_txn(1'b1, 4'hE, 3);
    check("lit_wrap_e", int'(rd_log[0]), 8'h77);
    check("lit_wrap_f", int'(rd_log[1]), 8'h33);
    check("lit_wrap_0", int'(rd_log[2]), 8'h11);
    rd_txn(1'b0, 4'h0, 1);
    check("lit_ptr_after_wrap", int'(rd_log[0]), 8'h22);

    mismatch(8'h40);
    wr_txn(8'h05, 32'h0000_003C, 1);

    for (int it = 0; it < 20; it++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: host_write(4'($urandom_range(0, 15)), 8'($urandom()));
        1: wr_txn(8'($urandom()), $urandom(), $urandom_range(1, 3));
        2: rd_txn(1'b1, 4'($urandom_range(0, 15)), $urandom_range(1, 3));
        3: rd_txn(1'b0, 4'h0, $urandom_range(1, 2));
        default: begin
          bad = 7'($urandom());
          if (bad == ADDR) bad = 7'h5A;
          mismatch({bad, 1'($urandom())});
          wr_txn(8'($urandom()), $urandom(), 1);
        end
      endcase
    end

    // Reset in the middle of a read while the target holds SDA low
    host_write(4'h0, 8'h0F);
    i2c_start();
    write_byte({ADDR, 1'b0}, ack); check("rr_addr_w_ack", int'(ack), 0);
    write_byte(8'h00, ack); check("rr_ptr_ack", int'(ack), 0);
    i2c_start();
    write_byte({ADDR, 1'b1}, ack); check("rr_addr_r_ack", int'(ack), 0);
    exp_match += 2;
    for (int i = 0; i < 3; i++) begin read_bit(v); check("rr_bit", int'(v), 0); end
    m_oe = 1'b0; wait_q(); scl = 1'b1; wait_q();
    check("rr_sda_driven", int'(sda_bus), 0);
    rst_n = 1'b0;
    #1;
    check("rr_sda_released", int'(sda_bus), 1);
    check("rr_match_count", seen_match, exp_match);
    model_reset();
    wait_q();
    rst_n = 1'b1;
    wait_q();
    rd_txn(1'b1, 4'h0, 1);
    check("lit_reg0_after_reset", int'(rd_log[0]), 8'h00);
    rd_txn(1'b1, 4'hF, 1);
    check("lit_whoami_after_reset", int'(rd_log[0]), 8'h33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
